// File: rtl/ifft_pipe_ctrl_if.sv
// Handshake and status bundle between the IFFT sample front end and the pipeline controller.
interface ifft_pipe_ctrl_if #(
    parameter int STAGES = 6
);
    logic              in_valid;
    logic              in_sop;
    logic [STAGES-2:0] twiddle_active;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic              busy;
    logic              err;

    modport master (
        output in_valid, in_sop,
        input  twiddle_active, out_valid, out_sop, out_eop, busy, err
    );

    modport slave (
        input  in_valid, in_sop,
        output twiddle_active, out_valid, out_sop, out_eop, busy, err
    );
endinterface

// File: rtl/ifft_pipe_ctrl.sv
// Frame controller for a radix-2 SDF IFFT pipeline: tracks every in-flight frame by its age
// and emits per-stage twiddle start pulses plus the framed output window.
module ifft_pipe_ctrl #(
    parameter int NFFT   = 64,
    parameter int STAGES = 6,
    parameter int PIPE   = 1
) (
    input  logic            clk,
    input  logic            rst,
    ifft_pipe_ctrl_if.slave bus
);
    localparam int LT    = (NFFT - 1) + STAGES * PIPE;
    localparam int LIFE  = LT + NFFT;
    localparam int NSLOT = (LIFE - 1) / NFFT + 1;
    localparam int AGE_W = $clog2(LIFE);
    localparam int CNT_W = $clog2(NFFT + 1);
    localparam int PTR_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Age (cycles after frame start) at which stage s kicks off its twiddle address generator.
    function automatic int twiddle_age(input int s);
        int acc;
        acc = (s - 1) * PIPE + (NFFT >> s);
        for (int i = 1; i < s; i++) acc += NFFT >> i;
        return acc;
    endfunction

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  in_cnt_reg, in_cnt_next;
    logic [PTR_W-1:0]  alloc_ptr_reg, alloc_ptr_next;
    logic [PTR_W-1:0]  cur_ptr_reg, cur_ptr_next;
    logic [NSLOT-1:0]  slot_active_reg, slot_active_next;
    logic [AGE_W-1:0]  slot_age_reg  [NSLOT];
    logic [AGE_W-1:0]  slot_age_next [NSLOT];
    logic              start, abort, err_next;

    logic [STAGES-2:0] tw_next, tw_reg;
    logic [NSLOT-1:0]  vld_hit, sop_hit, eop_hit;
    logic              out_valid_reg, out_sop_reg, out_eop_reg, busy_reg, err_reg;

    always_comb begin
        state_next     = state_reg;
        in_cnt_next    = in_cnt_reg;
        alloc_ptr_next = alloc_ptr_reg;
        cur_ptr_next   = cur_ptr_reg;
        start          = 1'b0;
        abort          = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            IDLE, DRAIN: start = bus.in_valid && bus.in_sop;
            RUN: begin
                if (in_cnt_reg == CNT_W'(NFFT)) begin
                    if (bus.in_valid && bus.in_sop) begin
                        start = 1'b1;
                    end else begin
                        err_next   = bus.in_valid;
                        state_next = DRAIN;
                    end
                end else if (!bus.in_valid) begin
                    err_next   = 1'b1;
                    abort      = 1'b1;
                    state_next = DRAIN;
                    // The aborted frame is always the newest allocation; hand its slot back.
                    alloc_ptr_next = cur_ptr_reg;
                end else begin
                    err_next    = bus.in_sop;
                    in_cnt_next = in_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (start) begin
            state_next     = RUN;
            in_cnt_next    = CNT_W'(1);
            cur_ptr_next   = alloc_ptr_reg;
            alloc_ptr_next = (alloc_ptr_reg == PTR_W'(NSLOT - 1)) ? '0 : alloc_ptr_reg + 1'b1;
        end

        for (int k = 0; k < NSLOT; k++) begin
            slot_active_next[k] = slot_active_reg[k] && (slot_age_reg[k] != AGE_W'(LIFE - 1));
            slot_age_next[k]    = slot_active_reg[k] ? slot_age_reg[k] + 1'b1 : slot_age_reg[k];
            if (start && alloc_ptr_reg == PTR_W'(k)) begin
                slot_active_next[k] = 1'b1;
                slot_age_next[k]    = '0;
            end
            if (abort && cur_ptr_reg == PTR_W'(k)) slot_active_next[k] = 1'b0;
        end

        if (state_next == DRAIN && slot_active_next == '0) state_next = IDLE;
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_tw
        localparam int TW_AGE = twiddle_age(gi);
        logic [NSLOT-1:0] hit;
        for (genvar gk = 0; gk < NSLOT; gk++) begin : g_slot
            assign hit[gk] = slot_active_next[gk] && (slot_age_next[gk] == AGE_W'(TW_AGE));
        end
        assign tw_next[gi-1] = |hit;
    end

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_win
        assign vld_hit[gi] = slot_active_next[gi] && (slot_age_next[gi] >= AGE_W'(LT));
        assign sop_hit[gi] = slot_active_next[gi] && (slot_age_next[gi] == AGE_W'(LT));
        assign eop_hit[gi] = slot_active_next[gi] && (slot_age_next[gi] == AGE_W'(LIFE - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            in_cnt_reg      <= '0;
            alloc_ptr_reg   <= '0;
            cur_ptr_reg     <= '0;
            slot_active_reg <= '0;
            for (int k = 0; k < NSLOT; k++) slot_age_reg[k] <= '0;
            tw_reg          <= '0;
            out_valid_reg   <= 1'b0;
            out_sop_reg     <= 1'b0;
            out_eop_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            in_cnt_reg      <= in_cnt_next;
            alloc_ptr_reg   <= alloc_ptr_next;
            cur_ptr_reg     <= cur_ptr_next;
            slot_active_reg <= slot_active_next;
            for (int k = 0; k < NSLOT; k++) slot_age_reg[k] <= slot_age_next[k];
            tw_reg          <= tw_next;
            out_valid_reg   <= |vld_hit;
            out_sop_reg     <= |sop_hit;
            out_eop_reg     <= |eop_hit;
            busy_reg        <= |slot_active_next;
            err_reg         <= err_next;
        end
    end

    assign bus.twiddle_active = tw_reg;
    assign bus.out_valid      = out_valid_reg;
    assign bus.out_sop        = out_sop_reg;
    assign bus.out_eop        = out_eop_reg;
    assign bus.busy           = busy_reg;
    assign bus.err            = err_reg;
endmodule

// File: tb/tb_ifft_pipe_ctrl.sv
// Bench for ifft_pipe_ctrl: PIPE=1 and PIPE=2 instances share stimulus and are checked every
// cycle against a frame-list reference model, plus absolute timing checks per scenario.
module tb_ifft_pipe_ctrl;
    localparam int NFFT   = 64;
    localparam int STAGES = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifft_pipe_ctrl_if #(.STAGES(STAGES)) bus  ();
    ifft_pipe_ctrl_if #(.STAGES(STAGES)) bus2 ();
    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_sop   = bus.in_sop;

    ifft_pipe_ctrl #(.NFFT(NFFT), .STAGES(STAGES), .PIPE(1)) dut    (.clk(clk), .rst(rst), .bus(bus));
    ifft_pipe_ctrl #(.NFFT(NFFT), .STAGES(STAGES), .PIPE(2)) dut_p2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {int t0; int ab;} frame_t;
    frame_t     frames[$];
    int         open_t0 = -1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [19:0] log_obs[$];
    logic [19:0] log_exp[$];
    int         log_cyc[$];
    int         cap_tw[5];
    int         sop_q[$];
    int         cap_eop, cap_busy_first, cap_busy_last, cap_err, ov_cnt;
    int         cap2_tw0, cap2_tw4, cap2_sop;

    function automatic int tw_age(input int s, input int pipe);
        int l = 0;
        for (int i = 1; i < s; i++) l += NFFT >> i;
        return l + (s - 1) * pipe + (NFFT >> s);
    endfunction

    // Expected {twiddle, out_valid, out_sop, out_eop, busy} at cycle c from the frame list.
    function automatic logic [8:0] expect_out(input int c, input int pipe);
        int lt, endc;
        logic [4:0] tw;
        logic ov, os, oe, bz;
        lt = NFFT - 1 + STAGES * pipe;
        tw = '0; ov = 0; os = 0; oe = 0; bz = 0;
        foreach (frames[i]) begin
            endc = (frames[i].ab >= 0) ? frames[i].ab - 1 : frames[i].t0 + lt + NFFT - 1;
            if (c >= frames[i].t0 && c <= endc) begin
                bz = 1;
                for (int s = 1; s < STAGES; s++)
                    if (c == frames[i].t0 + tw_age(s, pipe)) tw[s-1] = 1;
                if (c >= frames[i].t0 + lt) ov = 1;
                if (c == frames[i].t0 + lt) os = 1;
                if (c == frames[i].t0 + lt + NFFT - 1) oe = 1;
            end
        end
        return {tw, ov, os, oe, bz};
    endfunction

    task automatic model_step(input int c, input logic v, input logic s, output logic e);
        e = 1'b0;
        while (frames.size() > 0 && frames[0].t0 + 400 < c) void'(frames.pop_front());
        if (open_t0 >= 0 && c - open_t0 < NFFT) begin
            if (!v) begin
                e = 1'b1;
                frames[frames.size()-1].ab = c;
                open_t0 = -1;
                $display("frame aborted at cycle %0d", c);
            end else if (s) begin
                e = 1'b1;
            end
        end else if (v && s) begin
            frames.push_back('{t0: c, ab: -1});
            open_t0 = c;
            $display("frame start accepted at cycle %0d", c);
        end else begin
            if (v && open_t0 >= 0 && c == open_t0 + NFFT) e = 1'b1;
            open_t0 = -1;
        end
    endtask

    task automatic clear_capture();
        foreach (cap_tw[i]) cap_tw[i] = -1;
        sop_q.delete();
        log_obs.delete(); log_exp.delete(); log_cyc.delete();
        cap_eop = -1; cap_busy_first = -1; cap_busy_last = -1; cap_err = -1; ov_cnt = 0;
        cap2_tw0 = -1; cap2_tw4 = -1; cap2_sop = -1;
    endtask

    task automatic tick(input logic v, input logic s);
        logic e;
        logic [19:0] obs, exp_v;
        bus.in_valid = v;
        bus.in_sop   = s;
        @(posedge clk);
        cyc++;
        e = 1'b0;
        if (!rst) begin
            frames.delete();
            open_t0 = -1;
        end else begin
            model_step(cyc, v, s, e);
        end
        #1;
        obs = {bus.twiddle_active, bus.out_valid, bus.out_sop, bus.out_eop, bus.busy, bus.err,
               bus2.twiddle_active, bus2.out_valid, bus2.out_sop, bus2.out_eop, bus2.busy, bus2.err};
        exp_v = rst ? {expect_out(cyc, 1), e, expect_out(cyc, 2), e} : 20'b0;
        log_obs.push_back(obs); log_exp.push_back(exp_v); log_cyc.push_back(cyc);
        for (int i = 0; i < 5; i++) if (bus.twiddle_active[i] && cap_tw[i] < 0) cap_tw[i] = cyc;
        if (bus.out_sop) sop_q.push_back(cyc);
        if (bus.out_eop) cap_eop = cyc;
        if (bus.out_valid) ov_cnt++;
        if (bus.busy) begin
            if (cap_busy_first < 0) cap_busy_first = cyc;
            cap_busy_last = cyc;
        end
        if (bus.err && cap_err < 0) cap_err = cyc;
        if (bus2.twiddle_active[0] && cap2_tw0 < 0) cap2_tw0 = cyc;
        if (bus2.twiddle_active[4] && cap2_tw4 < 0) cap2_tw4 = cyc;
        if (bus2.out_sop && cap2_sop < 0) cap2_sop = cyc;
    endtask

    task automatic send_frame(input int drop_at, input int sop_at);
        tick(1'b1, 1'b1);
        for (int k = 1; k < NFFT; k++) begin
            if (k == drop_at)      tick(1'b0, 1'b0);
            else if (k == sop_at)  tick(1'b1, 1'b1);
            else                   tick(1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b1;
        #2 rst = 1'b0;
        #1;
        obs = {bus.twiddle_active, bus.out_valid, bus.out_sop, bus.out_eop, bus.busy, bus.err,
               bus2.twiddle_active, bus2.out_valid, bus2.out_sop, bus2.out_eop, bus2.busy, bus2.err};
        n_checks++;
        if (obs !== 20'b0) begin
            n_fail++;
            $display("FAIL reset_async outputs %b, expected %b", obs, 20'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        obs = {bus.twiddle_active, bus.out_valid, bus.out_sop, bus.out_eop, bus.busy, bus.err,
               bus2.twiddle_active, bus2.out_valid, bus2.out_sop, bus2.out_eop, bus2.busy, bus2.err};
        n_checks++;
        if (obs !== 20'b0) begin
            n_fail++;
            $display("FAIL reset_held outputs %b, expected %b", obs, 20'b0);
        end
        rst = 1'b1;
        clear_capture();
        repeat (4) tick(1'b0, 1'b0);
        foreach (log_obs[i]) begin
            n_checks++;
            if (log_obs[i] !== log_exp[i]) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d outputs %b, expected %b", log_cyc[i], log_obs[i], log_exp[i]);
            end
        end
    endtask

    task automatic test_single_frame();
        int t0;
        int exp_tw[5] = '{32, 49, 58, 63, 66};
        clear_capture();
        repeat (2) tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        t0 = cyc + 1;
        send_frame(-1, -1);
        repeat (90) tick(1'b0, 1'b0);
        foreach (log_obs[i]) begin
            n_checks++;
            if (log_obs[i] !== log_exp[i]) begin
                n_fail++;
                $display("FAIL single_model cycle %0d outputs %b, expected %b", log_cyc[i], log_obs[i], log_exp[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cap_tw[i] !== t0 + exp_tw[i]) begin
                n_fail++;
                $display("FAIL single_twiddle%0d at %0d, expected %0d", i, cap_tw[i], t0 + exp_tw[i]);
            end
        end
        n_checks++;
        if (sop_q.size() != 1 || sop_q[0] !== t0 + 69) begin
            n_fail++;
            $display("FAIL single_out_sop count %0d, expected one at %0d", sop_q.size(), t0 + 69);
        end
        n_checks++;
        if (cap_eop !== t0 + 132) begin
            n_fail++;
            $display("FAIL single_out_eop at %0d, expected %0d", cap_eop, t0 + 132);
        end
        n_checks++;
        if (ov_cnt !== 64) begin
            n_fail++;
            $display("FAIL single_out_valid cycles %0d, expected 64", ov_cnt);
        end
        n_checks++;
        if (cap_busy_first !== t0 || cap_busy_last !== t0 + 132) begin
            n_fail++;
            $display("FAIL single_busy %0d..%0d, expected %0d..%0d", cap_busy_first, cap_busy_last, t0, t0 + 132);
        end
        n_checks++;
        if (cap2_tw0 !== t0 + 32 || cap2_tw4 !== t0 + 70 || cap2_sop !== t0 + 75) begin
            n_fail++;
            $display("FAIL pipe2_timing tw0=%0d tw4=%0d sop=%0d, expected %0d %0d %0d",
                     cap2_tw0, cap2_tw4, cap2_sop, t0 + 32, t0 + 70, t0 + 75);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        clear_capture();
        t0 = cyc + 1;
        repeat (3) send_frame(-1, -1);
        repeat (140) tick(1'b0, 1'b0);
        foreach (log_obs[i]) begin
            n_checks++;
            if (log_obs[i] !== log_exp[i]) begin
                n_fail++;
                $display("FAIL b2b_model cycle %0d outputs %b, expected %b", log_cyc[i], log_obs[i], log_exp[i]);
            end
        end
        n_checks++;
        if (sop_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_sop_count %0d, expected 3", sop_q.size());
        end else begin
            for (int f = 0; f < 3; f++) begin
                n_checks++;
                if (sop_q[f] !== t0 + 69 + 64 * f) begin
                    n_fail++;
                    $display("FAIL b2b_sop%0d at %0d, expected %0d", f, sop_q[f], t0 + 69 + 64 * f);
                end
            end
        end
        n_checks++;
        if (ov_cnt !== 192 || cap_eop !== t0 + 260) begin
            n_fail++;
            $display("FAIL b2b_window valid=%0d eop=%0d, expected 192 %0d", ov_cnt, cap_eop, t0 + 260);
        end
    endtask

    task automatic test_abort();
        int t0;
        clear_capture();
        t0 = cyc + 1;
        send_frame(20, -1);
        repeat (100) tick(1'b0, 1'b0);
        foreach (log_obs[i]) begin
            n_checks++;
            if (log_obs[i] !== log_exp[i]) begin
                n_fail++;
                $display("FAIL abort_model cycle %0d outputs %b, expected %b", log_cyc[i], log_obs[i], log_exp[i]);
            end
        end
        n_checks++;
        if (cap_err !== t0 + 20 || ov_cnt !== 0 || cap_tw[0] !== -1 || cap_busy_last !== t0 + 19) begin
            n_fail++;
            $display("FAIL abort_effect err=%0d valid=%0d tw0=%0d busy_last=%0d, expected %0d 0 -1 %0d",
                     cap_err, ov_cnt, cap_tw[0], cap_busy_last, t0 + 20, t0 + 19);
        end
    endtask

    task automatic test_stray_sop();
        int t0;
        clear_capture();
        t0 = cyc + 1;
        send_frame(-1, 30);
        repeat (90) tick(1'b0, 1'b0);
        foreach (log_obs[i]) begin
            n_checks++;
            if (log_obs[i] !== log_exp[i]) begin
                n_fail++;
                $display("FAIL stray_model cycle %0d outputs %b, expected %b", log_cyc[i], log_obs[i], log_exp[i]);
            end
        end
        n_checks++;
        if (cap_err !== t0 + 30 || cap_tw[0] !== t0 + 32 || cap_eop !== t0 + 132 || sop_q.size() != 1) begin
            n_fail++;
            $display("FAIL stray_effect err=%0d tw0=%0d eop=%0d sops=%0d, expected %0d %0d %0d 1",
                     cap_err, cap_tw[0], cap_eop, sop_q.size(), t0 + 30, t0 + 32, t0 + 132);
        end
    endtask

    task automatic test_reset_mid();
        int t1;
        logic [19:0] obs;
        clear_capture();
        tick(1'b1, 1'b1);
        repeat (49) tick(1'b1, 1'b0);
        rst = 1'b0;
        #1;
        obs = {bus.twiddle_active, bus.out_valid, bus.out_sop, bus.out_eop, bus.busy, bus.err,
               bus2.twiddle_active, bus2.out_valid, bus2.out_sop, bus2.out_eop, bus2.busy, bus2.err};
        n_checks++;
        if (obs !== 20'b0) begin
            n_fail++;
            $display("FAIL midreset_async outputs %b, expected %b", obs, 20'b0);
        end
        repeat (2) tick(1'b1, 1'b0);
        rst = 1'b1;
        clear_capture();
        repeat (3) tick(1'b1, 1'b0);
        t1 = cyc + 1;
        send_frame(-1, -1);
        repeat (90) tick(1'b0, 1'b0);
        foreach (log_obs[i]) begin
            n_checks++;
            if (log_obs[i] !== log_exp[i]) begin
                n_fail++;
                $display("FAIL midreset_model cycle %0d outputs %b, expected %b", log_cyc[i], log_obs[i], log_exp[i]);
            end
        end
        n_checks++;
        if (cap_busy_first !== t1 || cap_tw[0] !== t1 + 32 || sop_q.size() != 1 || cap_eop !== t1 + 132) begin
            n_fail++;
            $display("FAIL midreset_restart busy=%0d tw0=%0d sops=%0d eop=%0d, expected %0d %0d 1 %0d",
                     cap_busy_first, cap_tw[0], sop_q.size(), cap_eop, t1, t1 + 32, t1 + 132);
        end
    endtask

    task automatic test_random();
        int gap, r;
        clear_capture();
        repeat (14) begin
            gap = $urandom_range(0, 3);
            repeat (gap) tick(1'($urandom_range(0, 1)), 1'b0);
            tick(1'b1, 1'b1);
            for (int k = 1; k < NFFT; k++) begin
                r = $urandom_range(0, 199);
                if (r == 0)      tick(1'b0, 1'b0);
                else if (r == 1) tick(1'b1, 1'b1);
                else             tick(1'b1, 1'b0);
            end
        end
        repeat (150) tick(1'b0, 1'b0);
        foreach (log_obs[i]) begin
            n_checks++;
            if (log_obs[i] !== log_exp[i]) begin
                n_fail++;
                $display("FAIL random_model cycle %0d outputs %b, expected %b", log_cyc[i], log_obs[i], log_exp[i]);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_abort();
        test_stray_sop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ifft_pipe_ctrl.md
IFFT_PIPE_CTRL -- requirements
Module: ifft_pipe_ctrl

Interface
REQ-001 Parameter NFFT, default 64, meaning points per frame; power of two.
REQ-002 Parameter STAGES, default 6, meaning log2(NFFT) radix-2 SDF stages.
REQ-003 Parameter PIPE, default 1, meaning register cycles per stage added after each stage's delay line.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  input sample present this cycle.
REQ-007 in_sop  input  1  first sample of a frame; qualified by in_valid.
REQ-008 twiddle_active  output  STAGES-1  one-cycle start pulse per twiddle address generator; bit s-1 is stage s.
REQ-009 out_valid  output  1  pipeline output sample valid.
REQ-010 out_sop  output  1  first output sample of a frame.
REQ-011 out_eop  output  1  last output sample of a frame.
REQ-012 busy  output  1  high whenever any frame is in flight.
REQ-013 err  output  1  one-cycle protocol-error pulse.

Function
REQ-014 States: IDLE, RUN, DRAIN.
REQ-015 Frame start t0 is the cycle with in_valid=1 and in_sop=1 accepted in IDLE, or in RUN exactly NFFT cycles after the previous t0.
REQ-016 Stage s offset: L_s = sum over i=1..s-1 of (NFFT>>i), plus (s-1)*PIPE; L_1=0.
REQ-017 twiddle_active[s-1] pulses for one cycle at t0+L_s+(NFFT>>s), for s=1..STAGES-1.
REQ-018 Total latency: LT = (NFFT-1) + STAGES*PIPE.
REQ-019 out_valid is high for t0+LT through t0+LT+NFFT-1.
REQ-020 out_sop is high at t0+LT only.
REQ-021 out_eop is high at t0+LT+NFFT-1 only.
REQ-022 IDLE -> RUN on an accepted frame start; in_valid without in_sop in IDLE is ignored, with no err.
REQ-023 RUN requires in_valid=1 for all NFFT cycles t0..t0+NFFT-1.
REQ-024 In RUN, at t0+NFFT: in_valid&in_sop starts the next frame (back-to-back, stay RUN); no in_valid -> DRAIN; in_valid without in_sop -> err pulse and DRAIN.
REQ-025 Overlapping frames are tracked independently; pulses and output windows of every accepted frame occur at their own offsets.
REQ-026 in_sop asserted mid-frame (not at t0+k*NFFT) pulses err and is ignored; the current frame continues.
REQ-027 in_valid dropped mid-frame pulses err on that cycle and aborts the current frame: none of its remaining twiddle pulses or output window are produced.
REQ-028 A mid-frame abort does not cancel earlier, fully-input frames; they complete normally.
REQ-029 DRAIN -> IDLE the cycle after the last in-flight frame's out_eop.
REQ-030 in_sop with in_valid in DRAIN is accepted as a new frame start (-> RUN); in-flight frames continue.
REQ-031 busy is high from t0 through the last in-flight out_eop, inclusive.
REQ-032 All outputs are registered; none depends combinationally on inputs.

Reset
REQ-033 On rst low: state=IDLE; all frame tracking is cleared; twiddle_active=0, out_valid=0, out_sop=0, out_eop=0, busy=0, err=0.
REQ-034 Reset asserted mid-operation discards all in-flight frames; no pulse or output follows release until a new frame start.

Verification
REQ-035 Defaults, single frame with sop at t0=10 -> twiddle_active bits 0..4 pulse at 42, 59, 68, 73, 76; out_valid at 79..142; out_sop at 79; out_eop at 142; busy at 10..142; IDLE at 143.
REQ-036 Three back-to-back frames with t0 = 10, 74, 138 -> each twiddle pattern repeats at +64 and +128; out_valid is continuous 79..270; out_sop at 79, 143, 207; out_eop at 142, 206, 270.
REQ-037 in_valid low at t0+20 -> err pulse that cycle; no pulses at or after t0+32 for that frame; out_valid never asserts; busy drops.
REQ-038 Extra in_sop at t0+30 -> err at t0+30; first frame timing is unchanged from REQ-035.
REQ-039 rst low at t0+50 for 2 cycles -> all outputs 0; no later pulses; the next sop at t+5 behaves as REQ-035 relative to its own t0.
REQ-040 PIPE=2 single frame -> LT=75; twiddle_active[0] pulses at t0+32 and twiddle_active[4] at t0+70.
